// File: rtl/trace_pkg.sv
// Shared types and default sizing for the trace capture controller and its helpers.
package trace_pkg;
    localparam int DEF_FPAY  = 32;
    localparam int DEF_TB_AW = 9;
    localparam int DEF_N_SRC = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        POST  = 3'd2,
        DONE  = 3'd3
    } state_t;

    function automatic int tb_depth(input int aw);
        return 2 ** aw;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer,
// pointer moves past the winner whenever the grant is consumed.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                win      = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= PW'((int'(win) + 1) % N);
        end
    end
endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace buffer sequencer: round-robin capture with a circular pre-trigger window,
// post-trigger word count, then one-word-per-request drain to the debug side.
// state | meaning: IDLE | off, ARMED | pre-trigger capture, POST | post-trigger capture, DONE | readout
module trace_capture_ctrl
    import trace_pkg::*;
#(
    parameter int Fpay  = DEF_FPAY,
    parameter int TB_AW = DEF_TB_AW,
    parameter int N_SRC = DEF_N_SRC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      src_valid,
    input  logic [N_SRC*Fpay-1:0] src_data,
    output logic [N_SRC-1:0]      src_grant,
    input  logic [N_SRC-1:0]      cfg_src_mask,
    input  logic [TB_AW:0]        cfg_post_cnt,
    input  logic                  arm,
    input  logic                  trig_in,
    input  logic                  dbg_rd_req,
    output logic [Fpay-1:0]       dbg_rd_data,
    output logic                  dbg_rd_valid,
    output logic                  buf_wr,
    output logic                  buf_rd,
    output logic [Fpay-1:0]       buf_din,
    input  logic [Fpay-1:0]       buf_dout,
    output logic [2:0]            state_o,
    output logic [TB_AW:0]        occupancy,
    output logic                  dropped
);
    localparam int             DEPTH_I = tb_depth(TB_AW);
    localparam logic [TB_AW:0] DEPTH   = DEPTH_I[TB_AW:0];
    localparam logic [TB_AW:0] ONE     = {{TB_AW{1'b0}}, 1'b1};

    state_t            state;
    logic [TB_AW:0]    post_left;
    logic [TB_AW:0]    post_clip;
    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  gnt;
    logic              capture;
    logic              wr;
    logic              full;
    logic              rd_fetch;
    logic [Fpay-1:0]   hold_data;

    assign capture = (state == ARMED) || (state == POST);
    assign req     = capture ? (src_valid & cfg_src_mask) : '0;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (wr),
        .gnt     (gnt)
    );

    assign wr        = |gnt;
    assign full      = (occupancy == DEPTH);
    assign rd_fetch  = (state == DONE) && dbg_rd_req && (occupancy != '0);
    // a write into a full buffer pops the oldest word so the window slides
    assign buf_rd    = (wr && full) || rd_fetch;
    assign buf_wr    = wr;
    assign src_grant = gnt;
    assign post_clip = (cfg_post_cnt > DEPTH) ? DEPTH : cfg_post_cnt;
    assign state_o   = state;
    assign dbg_rd_data = dbg_rd_valid ? buf_dout : hold_data;

    always_comb begin
        buf_din = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) buf_din = src_data[i*Fpay +: Fpay];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            post_left    <= '0;
            occupancy    <= '0;
            dropped      <= 1'b0;
            dbg_rd_valid <= 1'b0;
            hold_data    <= '0;
        end else begin
            dbg_rd_valid <= rd_fetch;
            if (dbg_rd_valid) hold_data <= buf_dout;

            if (wr && !buf_rd)      occupancy <= occupancy + ONE;
            else if (buf_rd && !wr) occupancy <= occupancy - ONE;

            if (wr && full) dropped <= 1'b1;

            case (state)
                IDLE: begin
                    if (arm) begin
                        state   <= ARMED;
                        dropped <= 1'b0;
                    end
                end
                ARMED: begin
                    // a write in the trigger cycle is still a pre-trigger word
                    if (trig_in) begin
                        post_left <= post_clip;
                        state     <= (post_clip == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (wr) begin
                        post_left <= post_left - ONE;
                        if (post_left == ONE) state <= DONE;
                    end
                end
                DONE: begin
                    if (arm && occupancy == '0) state <= ARMED;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: vector table, corner sequences and random traffic
// against a queue-based model of the trace window.
module tb_trace_capture_ctrl;
    localparam int FP    = 32;
    localparam int AW    = 3;
    localparam int NS    = 4;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NS-1:0]     src_valid;
    logic [NS*FP-1:0]  src_data;
    logic [NS-1:0]     src_grant;
    logic [NS-1:0]     cfg_src_mask;
    logic [AW:0]       cfg_post_cnt;
    logic              arm;
    logic              trig_in;
    logic              dbg_rd_req;
    logic [FP-1:0]     dbg_rd_data;
    logic              dbg_rd_valid;
    logic              buf_wr;
    logic              buf_rd;
    logic [FP-1:0]     buf_din;
    logic [FP-1:0]     buf_dout;
    logic [2:0]        state_o;
    logic [AW:0]       occupancy;
    logic              dropped;

    trace_capture_ctrl #(.Fpay(FP), .TB_AW(AW), .N_SRC(NS)) dut (
        .clk          (clk),
        .reset        (reset),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_grant    (src_grant),
        .cfg_src_mask (cfg_src_mask),
        .cfg_post_cnt (cfg_post_cnt),
        .arm          (arm),
        .trig_in      (trig_in),
        .dbg_rd_req   (dbg_rd_req),
        .dbg_rd_data  (dbg_rd_data),
        .dbg_rd_valid (dbg_rd_valid),
        .buf_wr       (buf_wr),
        .buf_rd       (buf_rd),
        .buf_din      (buf_din),
        .buf_dout     (buf_dout),
        .state_o      (state_o),
        .occupancy    (occupancy),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    // trace RAM with its own pointers and 1-cycle read latency
    logic [FP-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    always @(posedge clk) begin
        if (reset) begin
            wp <= '0; rp <= '0; buf_dout <= '0;
        end else begin
            if (buf_rd) begin buf_dout <= mem[rp]; rp <= rp + 1'b1; end
            if (buf_wr) begin mem[wp] <= buf_din; wp <= wp + 1'b1; end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: window contents as a queue, occupancy is its size
    int            m_state, m_rr, m_post;
    bit            m_drop, m_vld;
    logic [FP-1:0] m_data;
    logic [FP-1:0] m_q[$];
    logic [NS-1:0] p_gnt;
    bit            p_wr, p_rd;
    int            p_idx;
    logic [FP-1:0] p_din;

    task automatic predict();
        logic [NS-1:0] cand;
        cand  = src_valid & cfg_src_mask;
        p_gnt = '0; p_wr = 0; p_idx = -1; p_din = '0;
        if (m_state == 1 || m_state == 2) begin
            for (int k = 0; k < NS; k++) begin
                int i;
                i = (m_rr + k) % NS;
                if (p_idx < 0 && cand[i]) p_idx = i;
            end
        end
        if (p_idx >= 0) begin
            p_wr  = 1;
            p_gnt = 4'(1 << p_idx);
            p_din = src_data[p_idx*FP +: FP];
        end
        p_rd = (p_wr && m_q.size() == DEPTH) || (m_state == 3 && dbg_rd_req && m_q.size() > 0);
    endtask

    task automatic settle();
        #4;
        predict();
        chk("grant", src_grant, p_gnt);
        chk("buf_wr", buf_wr, p_wr);
        chk("buf_rd", buf_rd, p_rd);
        if (p_wr) chk("buf_din", buf_din, p_din);
        chk("state", state_o, m_state);
        chk("occupancy", occupancy, m_q.size());
        chk("dropped", dropped, m_drop);
        chk("rd_valid", dbg_rd_valid, m_vld);
        chk("rd_data", dbg_rd_data, m_data);
    endtask

    task automatic advance();
        int occ0;
        int c;
        logic [FP-1:0] tmp;
        @(posedge clk);
        occ0 = m_q.size();
        if (reset) begin
            m_state = 0; m_rr = 0; m_post = 0; m_drop = 0; m_vld = 0; m_data = '0;
            m_q.delete();
        end else begin
            m_vld = 0;
            if (p_wr) begin
                if (occ0 == DEPTH) begin tmp = m_q.pop_front(); m_drop = 1; end
                m_q.push_back(p_din);
                m_rr = (p_idx + 1) % NS;
            end
            if (m_state == 3 && dbg_rd_req && occ0 > 0) begin
                m_data = m_q.pop_front();
                m_vld  = 1;
            end
            case (m_state)
                0: if (arm) begin m_state = 1; m_drop = 0; end
                1: if (trig_in) begin
                       c = (int'(cfg_post_cnt) > DEPTH) ? DEPTH : int'(cfg_post_cnt);
                       if (c == 0) m_state = 3;
                       else begin m_state = 2; m_post = c; end
                   end
                2: if (p_wr) begin m_post--; if (m_post == 0) m_state = 3; end
                3: if (arm && occ0 == 0) m_state = 1;
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic clear_inputs();
        src_valid = '0; src_data = '0; cfg_src_mask = '1; cfg_post_cnt = '0;
        arm = 0; trig_in = 0; dbg_rd_req = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        advance();
        advance();
        reset = 0;
    endtask

    task automatic pulse_arm();
        arm = 1; settle(); advance(); arm = 0;
    endtask

    typedef struct {
        logic          arm;
        logic [NS-1:0] valid;
        logic [NS-1:0] mask;
        logic [NS-1:0] gnt;
        logic [FP-1:0] din;
        logic          rd;
        logic [2:0]    st;
        logic [AW:0]   occ;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 4'hF, 4'h0, 32'h00, 1'b0, 3'd0, 4'd0};
        tbl[1]  = '{1'b0, 4'hF, 4'hF, 4'h1, 32'hA0, 1'b0, 3'd1, 4'd0};
        tbl[2]  = '{1'b0, 4'hF, 4'hF, 4'h2, 32'hA1, 1'b0, 3'd1, 4'd1};
        tbl[3]  = '{1'b0, 4'hF, 4'hF, 4'h4, 32'hA2, 1'b0, 3'd1, 4'd2};
        tbl[4]  = '{1'b0, 4'hF, 4'hF, 4'h8, 32'hA3, 1'b0, 3'd1, 4'd3};
        tbl[5]  = '{1'b0, 4'hF, 4'hF, 4'h1, 32'hA0, 1'b0, 3'd1, 4'd4};
        tbl[6]  = '{1'b0, 4'hF, 4'h5, 4'h4, 32'hA2, 1'b0, 3'd1, 4'd5};
        tbl[7]  = '{1'b0, 4'hF, 4'h5, 4'h1, 32'hA0, 1'b0, 3'd1, 4'd6};
        tbl[8]  = '{1'b0, 4'hF, 4'h5, 4'h4, 32'hA2, 1'b0, 3'd1, 4'd7};
        tbl[9]  = '{1'b0, 4'hF, 4'h5, 4'h1, 32'hA0, 1'b1, 3'd1, 4'd8};
        tbl[10] = '{1'b0, 4'hF, 4'h5, 4'h4, 32'hA2, 1'b1, 3'd1, 4'd8};
        tbl[11] = '{1'b0, 4'h0, 4'h5, 4'h0, 32'h00, 1'b0, 3'd1, 4'd8};

        // reset state and round-robin / masking vectors
        do_reset();
        settle();
        chk("rst_state", state_o, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_grant", src_grant, 0);
        advance();
        for (int i = 0; i < NS; i++) src_data[i*FP +: FP] = 32'hA0 + i;
        for (int r = 0; r < 12; r++) begin
            arm = tbl[r].arm; src_valid = tbl[r].valid; cfg_src_mask = tbl[r].mask;
            settle();
            chk("tbl_grant", src_grant, tbl[r].gnt);
            if (tbl[r].gnt != 0) chk("tbl_din", buf_din, tbl[r].din);
            chk("tbl_rd", buf_rd, tbl[r].rd);
            chk("tbl_state", state_o, tbl[r].st);
            chk("tbl_occ", occupancy, tbl[r].occ);
            advance();
        end

        // overflow: 12 writes into an 8-deep window
        do_reset();
        pulse_arm();
        src_valid = 4'b0001;
        for (int w = 1; w <= 12; w++) begin
            src_data[FP-1:0] = w;
            settle();
            chk("ovf_wr", buf_wr, 1);
            chk("ovf_rd", buf_rd, w >= 9);
            chk("ovf_occ", occupancy, (w > 8) ? 8 : w - 1);
            advance();
        end
        src_valid = '0;
        settle();
        chk("ovf_dropped", dropped, 1);
        chk("ovf_occ_final", occupancy, 8);
        advance();

        // post count 3, trigger with write #5, then ordered readout
        do_reset();
        cfg_post_cnt = 3;
        pulse_arm();
        src_valid = 4'b0001;
        for (int n = 1; n <= 8; n++) begin
            src_data[FP-1:0] = 32'h100 + n;
            trig_in = (n == 5);
            settle();
            chk("post_wr", buf_wr, 1);
            chk("post_state", state_o, (n <= 5) ? 1 : 2);
            advance();
        end
        trig_in = 0;
        settle();
        chk("post_done", state_o, 3);
        chk("post_no_grant", src_grant, 0);
        chk("post_occ", occupancy, 8);
        advance();
        src_valid = '0;
        for (int k = 0; k <= 8; k++) begin
            dbg_rd_req = (k < 8);
            settle();
            chk("drain_rd", buf_rd, k < 8);
            if (k > 0) begin
                chk("drain_valid", dbg_rd_valid, 1);
                chk("drain_data", dbg_rd_data, 32'h100 + k);
            end
            advance();
        end
        dbg_rd_req = 0;
        settle();
        chk("drain_idle_valid", dbg_rd_valid, 0);
        chk("drain_hold", dbg_rd_data, 32'h108);
        chk("drain_occ", occupancy, 0);
        advance();

        // post count 0, arm ignored while data remains
        do_reset();
        cfg_post_cnt = 0;
        pulse_arm();
        src_valid = 4'b0001;
        for (int n = 1; n <= 3; n++) begin
            src_data[FP-1:0] = 32'h200 + n;
            trig_in = (n == 3);
            settle();
            advance();
        end
        trig_in = 0;
        settle();
        chk("p0_state", state_o, 3);
        chk("p0_no_wr", buf_wr, 0);
        chk("p0_occ", occupancy, 3);
        advance();
        pulse_arm();
        settle();
        chk("p0_arm_ignored", state_o, 3);
        advance();
        src_valid = '0;
        dbg_rd_req = 1;
        for (int k = 0; k < 3; k++) begin settle(); advance(); end
        settle();
        chk("empty_no_rd", buf_rd, 0);
        advance();
        dbg_rd_req = 0;
        settle();
        chk("empty_no_valid", dbg_rd_valid, 0);
        advance();
        pulse_arm();
        settle();
        chk("rearm_state", state_o, 1);
        advance();

        // readout request while armed is ignored
        dbg_rd_req = 1;
        settle();
        chk("armed_no_rd", buf_rd, 0);
        advance();
        dbg_rd_req = 0;
        settle();
        chk("armed_no_valid", dbg_rd_valid, 0);
        advance();

        // reset in POST after an overflow
        src_valid = 4'b0010;
        for (int n = 1; n <= 9; n++) begin
            src_data[2*FP-1:FP] = 32'h300 + n;
            settle(); advance();
        end
        cfg_post_cnt = 5;
        trig_in = 1;
        settle(); advance();
        trig_in = 0;
        settle();
        chk("mid_post_state", state_o, 2);
        chk("mid_post_dropped", dropped, 1);
        advance();
        reset = 1;
        settle(); advance();
        reset = 0;
        src_valid = '0;
        settle();
        chk("rst_post_state", state_o, 0);
        chk("rst_post_occ", occupancy, 0);
        chk("rst_post_dropped", dropped, 0);
        advance();

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            arm        = ($urandom_range(0, 9) == 0);
            trig_in    = ($urandom_range(0, 7) == 0);
            dbg_rd_req = $urandom_range(0, 1);
            src_valid  = 4'($urandom);
            if (c % 16 == 0) cfg_src_mask = 4'($urandom);
            cfg_post_cnt = 4'($urandom_range(0, 15));
            for (int i = 0; i < NS; i++) src_data[i*FP +: FP] = $urandom;
            settle();
            advance();
        end
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
